// File: rtl/aes_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_seq_pkg
// Brief    : Shared types, constants and RCON helper for the AES round sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package aes_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_SUB   = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  localparam logic [1:0] STATE_SEL_HOLD  = 2'b00;
  localparam logic [1:0] STATE_SEL_INIT  = 2'b01;
  localparam logic [1:0] STATE_SEL_ROUND = 2'b10;

  localparam logic [7:0] RCON_INIT         = 8'h01;
  localparam int         NUM_ROUNDS_AES128 = 10;

  // GF(2^8) multiply-by-2 used to step the round constant.
  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : load_sync_edge
// Brief    : 2-FF synchronizer for the MCU load level with fall/rise pulses.
// Revision : 1.0 - initial release
// ============================================================================
module load_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic start_p,
  output logic abort_p
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic       r_armed;
  logic [1:0] r_vld;

  // Reset preloads ones; a fall only counts once load has genuinely been
  // sampled high, so a low load across reset release cannot fake a start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_vld   <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= load;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_vld   <= {r_vld[0], 1'b1};
      r_armed <= r_armed | (r_vld[1] & r_sync2);
    end
  end

  assign start_p = r_armed & r_prev & ~r_sync2;
  assign abort_p = ~r_prev & r_sync2;

endmodule
`default_nettype wire

// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_sequencer
// Brief    : Iterative AES-128 control FSM: load detect, initial key add,
//            ten S-box-waited rounds, then done until the next load.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int NUM_ROUNDS  = NUM_ROUNDS_AES128,
  parameter int SUB_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  output logic [1:0] state_sel,
  output logic       state_en,
  output logic       key_sel,
  output logic       key_en,
  output logic       mix_bypass,
  output logic       sub_phase,
  output logic [7:0] rcon,
  output logic [3:0] round,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] c_wait_init  = 2'(SUB_LATENCY - 1);
  localparam logic [3:0] c_last_round = 4'(NUM_ROUNDS);

  logic       w_start;
  logic       w_abort;

  seq_state_t r_state;
  seq_state_t w_state_nxt;
  logic [3:0] r_round;
  logic [3:0] w_round_nxt;
  logic [7:0] r_rcon;
  logic [7:0] w_rcon_nxt;
  logic [1:0] r_wait;
  logic [1:0] w_wait_nxt;

  load_sync_edge u_load_sync (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .start_p (w_start),
    .abort_p (w_abort)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_round <= 4'd0;
      r_rcon  <= RCON_INIT;
      r_wait  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      r_rcon  <= w_rcon_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // Abort is checked first in every state so it wins over any other move.
  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_rcon_nxt  = r_rcon;
    w_wait_nxt  = r_wait;
    if (w_abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_round_nxt = 4'd0;
      w_rcon_nxt  = RCON_INIT;
      w_wait_nxt  = 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start && !w_abort) begin
            w_state_nxt = ST_INIT;
          end
        end
        ST_INIT: begin
          w_state_nxt = ST_SUB;
          w_round_nxt = 4'd1;
          w_rcon_nxt  = RCON_INIT;
          w_wait_nxt  = c_wait_init;
        end
        ST_SUB: begin
          if (r_wait == 2'd0) begin
            w_state_nxt = ST_ROUND;
          end else begin
            w_wait_nxt = r_wait - 2'd1;
          end
        end
        ST_ROUND: begin
          if (r_round == c_last_round) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_SUB;
            w_round_nxt = r_round + 4'd1;
            w_rcon_nxt  = xtime(r_rcon);
            w_wait_nxt  = c_wait_init;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_round_nxt = 4'd0;
          w_rcon_nxt  = RCON_INIT;
          w_wait_nxt  = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    state_sel  = STATE_SEL_HOLD;
    state_en   = 1'b0;
    key_sel    = 1'b0;
    key_en     = 1'b0;
    mix_bypass = 1'b0;
    sub_phase  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      ST_INIT: begin
        state_sel = STATE_SEL_INIT;
        state_en  = 1'b1;
        key_en    = 1'b1;
        busy      = 1'b1;
      end
      ST_SUB: begin
        sub_phase = 1'b1;
        busy      = 1'b1;
      end
      ST_ROUND: begin
        state_sel  = STATE_SEL_ROUND;
        state_en   = 1'b1;
        key_sel    = 1'b1;
        key_en     = 1'b1;
        busy       = 1'b1;
        mix_bypass = (r_round == c_last_round);
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  assign round = r_round;
  assign rcon  = r_rcon;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_sequencer
// Brief    : Self-checking bench; runs SUB_LATENCY=1 and =3 copies side by side
//            against a timeline model of the round schedule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_sequencer;

  logic clk;
  logic reset;
  logic load;
  int   cyc;

  logic [1:0] state_sel1, state_sel3;
  logic       state_en1, state_en3, key_sel1, key_sel3, key_en1, key_en3;
  logic       mix_bypass1, mix_bypass3, sub_phase1, sub_phase3;
  logic [7:0] rcon1, rcon3;
  logic [3:0] round1, round3;
  logic       busy1, busy3, done1, done3;

  logic [20:0] obs1, obs3;

  int total;
  int bad;
  int init_cyc;
  int stop_cyc;
  logic [7:0] rcon_tbl [10];

  aes_round_sequencer #(.NUM_ROUNDS(10), .SUB_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .load(load),
    .state_sel(state_sel1), .state_en(state_en1), .key_sel(key_sel1), .key_en(key_en1),
    .mix_bypass(mix_bypass1), .sub_phase(sub_phase1), .rcon(rcon1), .round(round1),
    .busy(busy1), .done(done1)
  );

  aes_round_sequencer #(.NUM_ROUNDS(10), .SUB_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .load(load),
    .state_sel(state_sel3), .state_en(state_en3), .key_sel(key_sel3), .key_en(key_en3),
    .mix_bypass(mix_bypass3), .sub_phase(sub_phase3), .rcon(rcon3), .round(round3),
    .busy(busy3), .done(done3)
  );

  assign obs1 = {state_sel1, state_en1, key_sel1, key_en1, mix_bypass1, sub_phase1,
                 busy1, done1, round1, rcon1};
  assign obs3 = {state_sel3, state_en3, key_sel3, key_en3, mix_bypass3, sub_phase3,
                 busy3, done3, round3, rcon3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs from the cycle offset since INIT: one INIT cycle, then per
  // round lat SUB cycles and one ROUND cycle, then DONE until aborted.
  function automatic logic [20:0] exp_out(input int lat, input int c);
    logic [1:0] sel;
    logic       sen, ksel, ken, mix, sub, bsy, dn;
    logic [3:0] rnd;
    logic [7:0] rc;
    int         k, r, ph;
    sel = 2'b00; sen = 1'b0; ksel = 1'b0; ken = 1'b0; mix = 1'b0;
    sub = 1'b0; bsy = 1'b0; dn = 1'b0; rnd = 4'd0; rc = 8'h01;
    if (init_cyc >= 0 && c >= init_cyc && c < stop_cyc) begin
      k = c - init_cyc;
      if (k == 0) begin
        sel = 2'b01; sen = 1'b1; ken = 1'b1; bsy = 1'b1;
      end else if (k <= 10 * (lat + 1)) begin
        r   = (k - 1) / (lat + 1) + 1;
        ph  = (k - 1) % (lat + 1);
        rnd = 4'(r);
        rc  = rcon_tbl[r-1];
        bsy = 1'b1;
        if (ph < lat) begin
          sub = 1'b1;
        end else begin
          sel = 2'b10; sen = 1'b1; ksel = 1'b1; ken = 1'b1; mix = (r == 10);
        end
      end else begin
        dn = 1'b1; rnd = 4'd10; rc = rcon_tbl[9];
      end
    end
    return {sel, sen, ksel, ken, mix, sub, bsy, dn, rnd, rc};
  endfunction

  task automatic tick();
    logic [20:0] e1, e3;
    @(negedge clk);
    e1 = exp_out(1, cyc);
    e3 = exp_out(3, cyc);
    total++;
    assert (obs1 === e1) else begin
      bad++;
      $error("FAIL lat1 cyc=%0d observed=%h expected=%h", cyc, obs1, e1);
    end
    total++;
    assert (obs3 === e3) else begin
      bad++;
      $error("FAIL lat3 cyc=%0d observed=%h expected=%h", cyc, obs3, e3);
    end
  endtask

  task automatic run_until(input int target);
    while (cyc < target) tick();
  endtask

  // Load edges take two sync stages plus the edge detect before the FSM moves.
  task automatic fall();
    load     = 1'b0;
    init_cyc = cyc + 3;
    stop_cyc = 32'h3fff_ffff;
  endtask

  task automatic rise();
    load = 1'b1;
    if (stop_cyc > cyc + 3) stop_cyc = cyc + 3;
  endtask

  task automatic load_phase();
    rise();
    repeat ($urandom_range(4, 12)) tick();
    fall();
  endtask

  initial begin
    int ab;
    rcon_tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    total    = 0;
    bad      = 0;
    init_cyc = -1;
    stop_cyc = 0;
    reset    = 1'b0;
    load     = 1'b0;

    repeat (3) tick();
    reset = 1'b1;
    repeat (6) tick();

    // Full run for both latencies, then a long DONE hold and abort out of DONE.
    load_phase();
    run_until(init_cyc + 45);
    repeat (100) tick();

    // Abort while the latency-1 copy sits in the S-box wait of round 5.
    load_phase();
    run_until(init_cyc + 7);
    rise();
    repeat ($urandom_range(4, 10)) tick();
    fall();
    run_until(init_cyc + 45);

    // Reset during the round-7 ROUND cycle of the latency-1 copy.
    load_phase();
    run_until(init_cyc + 14);
    reset = 1'b0;
    if (stop_cyc > cyc + 1) stop_cyc = cyc + 1;
    repeat (2) tick();
    reset = 1'b1;
    repeat (5) tick();
    load_phase();
    run_until(init_cyc + 45);

    for (int t = 0; t < 5; t++) begin
      load_phase();
      ab = $urandom_range(0, 50);
      run_until(init_cyc + ab);
      rise();
      repeat ($urandom_range(3, 8)) tick();
    end
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Control unit for an iterative (one-round-per-pass) AES-128 encryption datapath. It detects the end of the SPI load phase and sequences the initial AddRoundKey and ten rounds, including waits for the synchronous S-box. It drives the state/key register enables, mux selects, MixColumns bypass and RCON, then holds done until the next load. It sits between the aes_spi load/done pins and the core datapath, replacing the fixed-delay state chain.

Parameters:
NUM_ROUNDS, 10, round count (AES-128); legal value is 10 only, kept as a parameter for assertions.
SUB_LATENCY, 1, cycles from S-box address to valid S-box data (EBR read); legal range 1..3.

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-low
load  in  1  asynchronous level from the MCU; high while the key and plaintext are being shifted in
state_sel  out  2  state register input mux: 00 hold, 01 plaintext^key, 10 round result
state_en  out  1  state register load enable
key_sel  out  1  round-key register mux: 0 cipher key, 1 expanded next key
key_en  out  1  round-key register load enable
mix_bypass  out  1  skip MixColumns (final round)
sub_phase  out  1  S-box lookup in flight
rcon  out  8  round constant for the key expansion of the current round
round  out  4  current round number, 0..10
busy  out  1  sequence in progress
done  out  1  ciphertext valid in the state register

Behaviour:
- Reset (reset==0 at clk edge):
  - state IDLE, round=0, rcon=8'h01.
  - All enables, selects, mix_bypass, sub_phase, busy and done are 0.
  - Synchronizer flops cleared to 1, so no false edge is seen out of reset.
- load synchronization:
  - 2-FF synchronizer, then a falling-edge detect producing a 1-cycle start pulse.
  - A rising edge produces a 1-cycle abort pulse.
- FSM states: IDLE, INIT, SUB, ROUND, DONE. All outputs are decoded from registered state, round and rcon (Moore).
  - IDLE: all outputs 0. start -> INIT.
  - INIT (1 cycle):
    - state_sel=01, state_en=1, key_sel=0, key_en=1, busy=1.
    - Next: round<=1, rcon<=01, -> SUB.
  - SUB (SUB_LATENCY cycles, internal wait counter):
    - sub_phase=1, busy=1, no enables.
    - Counter expiry -> ROUND.
  - ROUND (1 cycle):
    - state_sel=10, state_en=1, key_sel=1, key_en=1, busy=1, mix_bypass=(round==NUM_ROUNDS).
    - If round==NUM_ROUNDS -> DONE.
    - Else round<=round+1, rcon<=xtime(rcon), -> SUB.
  - DONE: done=1, busy=0, all enables 0, round holds at 10. Abort (load rises) -> IDLE.
- xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1B : 8'h00). Sequence: 01 02 04 08 10 20 40 80 1B 36.
- Latency: start pulse -> INIT next cycle. INIT entry -> DONE entry = 1 + NUM_ROUNDS*(SUB_LATENCY+1) cycles, i.e. 21 at the default.
- Abort in any busy state (INIT/SUB/ROUND):
  - -> IDLE next cycle; round=0, rcon=01; done stays 0.
  - Partial state register contents are don't-care.
- start while busy cannot occur (a fall requires a prior rise, which aborts). If start and abort coincide through glitch filtering, abort wins.
- start in DONE is impossible without a preceding abort. The sequence is always IDLE -> INIT.
- Reset mid-operation: same as the reset values above, taking effect on the next clk.

Decomposition:
- Package aes_seq_pkg:
  - seq_state_t enum.
  - STATE_SEL_HOLD/INIT/ROUND localparams.
  - RCON_INIT=8'h01, NUM_ROUNDS_AES128=10.
  - xtime function.
- Sub-module load_sync_edge: 2-FF synchronizer plus edge detector; outputs start_p and abort_p.

Test Plan:
- Reset low 3 cycles, load=0 -> all outputs 0, rcon=01, round=0, no start pulse after reset release.
- load 1->0, SUB_LATENCY=1 -> INIT 3 cycles after the fall (2 sync + 1 edge); done rises exactly 21 cycles after INIT. Enable pulses as specified, rcon sequence 01..36 checked on each ROUND cycle, mix_bypass=1 only in round 10.
- SUB_LATENCY=3 -> sub_phase high for 3 cycles per round; INIT-to-DONE = 41 cycles.
- load rises during round 5 SUB -> IDLE next cycle after abort_p, busy=0, done never asserted; a new fall restarts with round 1, rcon=01.
- In DONE, hold load low 100 cycles -> done stays 1, no enables; load rises -> done falls 3 cycles later.
- reset asserted during ROUND of round 7 -> all outputs at reset values on the next clk; a subsequent load fall runs a full correct sequence.
